// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx
//   Frame serialiser. A frame is one start bit (0), DATA_W payload bits sent
//   LSB first, and one stop bit (1). Each bit is held on tx for BAUD_DIV clock
//   cycles, so a frame lasts (DATA_W+2)*BAUD_DIV cycles. All outputs come
//   straight from registers.
//
// Parameters
//   DATA_W    payload bits per frame (1..16)
//   BAUD_DIV  clock cycles per serial bit (1..1024)
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   asynchronous active-high reset
//   data_in  in   payload, captured only on the edge that accepts start
//   start    in   transmit request, level-sampled on every rising edge
//   tx       out  serial line, idles high
//   busy     out  high while a frame is in progress
//   done     out  one-cycle pulse in the first idle cycle after a frame
// -----------------------------------------------------------------------------
module serial_tx #(
    parameter int DATA_W   = 8,
    parameter int BAUD_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              start,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    // Counter widths are clamped to at least one bit so DATA_W=1 / BAUD_DIV=1
    // still produce legal vectors.
    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  baud_cnt_reg;
    logic [IDX_W-1:0]  bit_idx_reg;
    logic [DATA_W-1:0] data_reg;
    logic              tx_reg;
    logic              busy_reg;
    logic              done_reg;

    logic              bit_end;
    logic [IDX_W-1:0]  idx_next;

    // Last cycle of the current bit period: the next edge moves to a new bit.
    assign bit_end  = (baud_cnt_reg == CNT_LAST);
    // Only used to select the next payload bit while more bits remain, so it
    // never addresses past DATA_W-1 on a path that reaches tx.
    assign idx_next = bit_idx_reg + IDX_W'(1);

    assign tx   = tx_reg;
    assign busy = busy_reg;
    assign done = done_reg;

    // tx is loaded one edge ahead with the value of the bit about to start,
    // which gives the one-cycle start latency and keeps tx glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            data_reg     <= '0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    tx_reg   <= 1'b1;
                    busy_reg <= 1'b0;
                    // Includes the done cycle, so back-to-back frames chain
                    // without an extra idle cycle.
                    if (start) begin
                        data_reg     <= data_in;
                        state_reg    <= START;
                        tx_reg       <= 1'b0;
                        busy_reg     <= 1'b1;
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                    end
                end

                START: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        state_reg    <= DATA;
                        tx_reg       <= data_reg[0];
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        if (bit_idx_reg == IDX_LAST) begin
                            bit_idx_reg <= '0;
                            state_reg   <= STOP;
                            tx_reg      <= 1'b1;
                        end else begin
                            bit_idx_reg <= idx_next;
                            tx_reg      <= data_reg[idx_next];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        state_reg    <= IDLE;
                        tx_reg       <= 1'b1;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_tx
//   Directed bench for serial_tx. dut_a uses DATA_W=8, BAUD_DIV=4; dut_b uses
//   DATA_W=8, BAUD_DIV=1. Inputs change 1 time unit after a rising edge and
//   outputs are sampled at the same point, i.e. well away from the edge.
// -----------------------------------------------------------------------------
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a;
    logic       start_b;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    serial_tx #(.DATA_W(8), .BAUD_DIV(4)) dut_a (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_a),
        .start   (start_a),
        .tx      (tx_a),
        .busy    (busy_a),
        .done    (done_a)
    );

    serial_tx #(.DATA_W(8), .BAUD_DIV(1)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_b),
        .start   (start_b),
        .tx      (tx_b),
        .busy    (busy_b),
        .done    (done_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Sends d on dut_a and checks all 40 frame cycles plus the done cycle.
    // At cycle poke_cyc (0 = never) start_a/data_a are set to poke_start/poke_d
    // for the following edge. Returns with dut_a in its done cycle, start_a=0.
    task automatic send_a(input string name, input logic [7:0] d,
                          input int poke_cyc, input logic [7:0] poke_d,
                          input logic poke_start);
        logic [9:0] fb;
        logic       exp_tx;
        fb = {1'b1, d, 1'b0};
        start_a = 1'b1;
        data_a  = d;
        tick();
        start_a = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            exp_tx = fb[(c - 1) / 4];
            tests_run++;
            if (tx_a !== exp_tx || busy_a !== 1'b1 || done_a !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s cycle %0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=0",
                         name, c, tx_a, busy_a, done_a, exp_tx);
            end
            if (c == poke_cyc) begin
                start_a = poke_start;
                data_a  = poke_d;
            end else begin
                start_a = 1'b0;
            end
            tick();
        end
        start_a = 1'b0;
        tests_run++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s done cycle 41: tx=%b busy=%b done=%b, required tx=1 busy=0 done=1",
                     name, tx_a, busy_a, done_a);
        end
        $display("[TB] %s: frame 0x%02h checked (%0d failures so far)", name, d, tests_failed);
    endtask

    // Line must stay idle: tx=1, busy=0, done=0 for n cycles.
    task automatic check_idle(input string name, input int n);
        for (int c = 1; c <= n; c++) begin
            tick();
            tests_run++;
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s idle %0d: tx=%b busy=%b done=%b, required tx=1 busy=0 done=0",
                         name, c, tx_a, busy_a, done_a);
            end
        end
    endtask

    task automatic test_reset;
        rst     = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        data_a  = 8'h00;
        data_b  = 8'h00;
        #2 rst  = 1'b1;
        #1;
        tests_run++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 ||
            tx_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: a tx=%b busy=%b done=%b b tx=%b busy=%b done=%b, required tx=1 busy=0 done=0",
                     tx_a, busy_a, done_a, tx_b, busy_b, done_b);
        end
        tick();
        tick();
        rst = 1'b0;
        $display("[TB] reset: outputs checked");
    endtask

    task automatic test_send_a5;
        send_a("send_a5", 8'hA5, 0, 8'h00, 1'b0);
        check_idle("send_a5", 3);
    endtask

    task automatic test_back_to_back;
        send_a("b2b_first", 8'h00, 0, 8'h00, 1'b0);
        // start is raised in the done cycle; send_a checks tx=0 next cycle
        send_a("b2b_second", 8'hFF, 0, 8'h00, 1'b0);
        check_idle("b2b", 2);
    endtask

    task automatic test_start_while_busy;
        send_a("start_busy", 8'hA5, 10, 8'h3C, 1'b1);
        check_idle("start_busy", 50);
    endtask

    task automatic test_reset_mid_frame;
        start_a = 1'b1;
        data_a  = 8'hA5;
        tick();
        start_a = 1'b0;
        repeat (16) tick();
        // cycle 17 carries data bit 3 of 0xA5, which is 0
        tests_run++;
        if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid pre: tx=%b busy=%b, required tx=0 busy=1", tx_a, busy_a);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid abort: tx=%b busy=%b done=%b, required tx=1 busy=0 done=0",
                     tx_a, busy_a, done_a);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        $display("[TB] rst_mid: abort checked");
        send_a("rst_mid_resend", 8'hA5, 0, 8'h00, 1'b0);
        check_idle("rst_mid", 2);
    endtask

    task automatic test_data_change;
        send_a("data_change", 8'hFF, 1, 8'h00, 1'b0);
        check_idle("data_change", 2);
    endtask

    task automatic test_baud_div1;
        logic [9:0] fb;
        fb = {1'b1, 8'h81, 1'b0};
        start_b = 1'b1;
        data_b  = 8'h81;
        tick();
        start_b = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tests_run++;
            if (tx_b !== fb[c - 1] || busy_b !== 1'b1 || done_b !== 1'b0) begin
                tests_failed++;
                $display("FAIL baud1 cycle %0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=0",
                         c, tx_b, busy_b, done_b, fb[c - 1]);
            end
            tick();
        end
        tests_run++;
        if (tx_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL baud1 done cycle 11: tx=%b busy=%b done=%b, required tx=1 busy=0 done=1",
                     tx_b, busy_b, done_b);
        end
        tick();
        tests_run++;
        if (tx_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL baud1 after done: tx=%b busy=%b done=%b, required tx=1 busy=0 done=0",
                     tx_b, busy_b, done_b);
        end
        $display("[TB] baud1: frame 0x81 checked (%0d failures so far)", tests_failed);
    endtask

    initial begin
        test_reset();
        test_send_a5();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid_frame();
        test_data_change();
        test_baud_div1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
